// File: rtl/seq_detect_pkg.sv
// Shared constants and types for the programmable serial sequence detector.
package seq_detect_pkg;

  localparam int DEF_PATTERN_W = 4;
  localparam int DEF_COUNT_W   = 8;

  // First bit in time is the MSB.
  localparam logic [DEF_PATTERN_W-1:0] DEF_PATTERN = 4'b1101;

  // Fill counter must represent 0..PATTERN_W inclusive.
  function automatic int fill_width(input int pattern_w);
    return $clog2(pattern_w + 1);
  endfunction

  localparam int DEF_FILL_W = fill_width(DEF_PATTERN_W);
  typedef logic [DEF_FILL_W-1:0] fill_t;

  // History update selected by the top for each edge.
  typedef enum logic [1:0] {
    HIST_HOLD,
    HIST_SHIFT,
    HIST_RESTART,
    HIST_CLEAR
  } hist_op_e;

endpackage

// File: rtl/seq_detect_hist.sv
// Bit history shift register and fill counter for seq_detect_prog.
// Exposes the next-state values so the top can register the match flag
// with the same edge that samples the final pattern bit.
module seq_detect_hist
  import seq_detect_pkg::*;
#(
  parameter int PATTERN_W = DEF_PATTERN_W,
  parameter int FILL_W    = fill_width(PATTERN_W)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  hist_op_e             op,
  input  logic                 bit_in,
  output logic [PATTERN_W-1:0] hist_next,
  output logic [FILL_W-1:0]    fill_next
);

  logic [PATTERN_W-1:0] hist;
  logic [FILL_W-1:0]    fill;

  // Next history/fill for the requested operation.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    hist_next = hist;
    fill_next = fill;
    case (op)
      HIST_SHIFT: begin
        hist_next = {hist[PATTERN_W-2:0], bit_in};
        fill_next = (fill == FILL_W'(PATTERN_W)) ? fill : fill + FILL_W'(1);
      end
      HIST_RESTART: begin
        hist_next = {{(PATTERN_W-1){1'b0}}, bit_in};
        fill_next = FILL_W'(1);
      end
      HIST_CLEAR: begin
        hist_next = '0;
        fill_next = '0;
      end
      default: ;
    endcase
  end

  // History and fill registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= hist_next;
      fill <= fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable Moore serial sequence detector with overlap control,
// input qualifier and saturating match counter.
// Optional don't-care mask: define SEQ_DETECT_PROG_MASK_EN to add mask_in and
// a mask register (reset all-ones, loaded with the pattern).
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int                   PATTERN_W       = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = PATTERN_W'(DEF_PATTERN),
  parameter int                   COUNT_W         = DEF_COUNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 pattern_load,
  input  logic [PATTERN_W-1:0] pattern_in,
`ifdef SEQ_DETECT_PROG_MASK_EN
  input  logic [PATTERN_W-1:0] mask_in,
`endif
  input  logic                 overlap_en,
  input  logic                 count_clear,
  output logic                 out_flag,
  output logic [COUNT_W-1:0]   match_count
);

  localparam int FILL_W = fill_width(PATTERN_W);

  hist_op_e             op;
  logic [PATTERN_W-1:0] hist_next;
  logic [FILL_W-1:0]    fill_next;
  logic [PATTERN_W-1:0] pattern_q;
  logic [PATTERN_W-1:0] cmp_mask;
  logic                 match_next;
  logic                 consumed;
  logic                 match_event;

  // Choose the history operation; a load wins over a coincident bit.
  always_comb begin
    op = HIST_HOLD;
    if (pattern_load) begin
      op = HIST_CLEAR;
    end else if (bit_valid) begin
      op = (overlap_en || !out_flag) ? HIST_SHIFT : HIST_RESTART;
    end
  end

  seq_detect_hist #(
    .PATTERN_W (PATTERN_W),
    .FILL_W    (FILL_W)
  ) u_hist (
    .clock     (clock),
    .reset     (reset),
    .op        (op),
    .bit_in    (bit_in),
    .hist_next (hist_next),
    .fill_next (fill_next)
  );

`ifdef SEQ_DETECT_PROG_MASK_EN
  logic [PATTERN_W-1:0] mask_q;

  // Pattern and mask registers, reprogrammed together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pattern_q <= DEFAULT_PATTERN;
      mask_q    <= '1;
    end else if (pattern_load) begin
      pattern_q <= pattern_in;
      mask_q    <= mask_in;
    end
  end

  assign cmp_mask = mask_q;
`else
  // Pattern register, reprogrammed by pattern_load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pattern_q <= DEFAULT_PATTERN;
    end else if (pattern_load) begin
      pattern_q <= pattern_in;
    end
  end

  assign cmp_mask = '1;
`endif

  // Compare on next state so out_flag rises right after the final bit's edge.
  // A load clears fill, so the stale pattern can never produce a match.
  assign match_next  = (fill_next == FILL_W'(PATTERN_W)) &&
                       (((hist_next ^ pattern_q) & cmp_mask) == '0);
  assign consumed    = bit_valid && !pattern_load;
  assign match_event = match_next && (!out_flag || consumed);

  // Registered match flag and saturating match counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_flag    <= 1'b0;
      match_count <= '0;
    end else begin
      out_flag <= match_next;
      if (count_clear) begin
        match_count <= '0;
      end else if (match_event && (match_count != '1)) begin
        match_count <= match_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: expected flag/count values are
// queued as stimulus is driven and compared after each active edge.
module tb_seq_detect_prog;

  logic       clock;
  logic       reset;
  logic       bit_valid;
  logic       bit_in;
  logic       pattern_load;
  logic [3:0] pattern_in;
  logic       overlap_en;
  logic       count_clear;
  logic       out_flag;
  logic [7:0] match_count;
  logic       out_flag2;
  logic [1:0] match_count2;

  typedef struct {
    logic       flag;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  seq_detect_prog dut (
    .clock        (clock),
    .reset        (reset),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .pattern_load (pattern_load),
    .pattern_in   (pattern_in),
`ifdef SEQ_DETECT_PROG_MASK_EN
    .mask_in      (4'hF),
`endif
    .overlap_en   (overlap_en),
    .count_clear  (count_clear),
    .out_flag     (out_flag),
    .match_count  (match_count)
  );

  seq_detect_prog #(.COUNT_W(2)) dut2 (
    .clock        (clock),
    .reset        (reset),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .pattern_load (pattern_load),
    .pattern_in   (pattern_in),
`ifdef SEQ_DETECT_PROG_MASK_EN
    .mask_in      (4'hF),
`endif
    .overlap_en   (overlap_en),
    .count_clear  (count_clear),
    .out_flag     (out_flag2),
    .match_count  (match_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input logic v, input logic b, input logic ld,
                       input logic [3:0] pat, input logic clr);
    @(negedge clock);
    bit_valid    = v;
    bit_in       = b;
    pattern_load = ld;
    pattern_in   = pat;
    count_clear  = clr;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    bit_valid    = 1'b0;
    bit_in       = 1'b0;
    pattern_load = 1'b0;
    pattern_in   = 4'h0;
    count_clear  = 1'b0;
    overlap_en   = 1'b1;
    reset        = 1'b0;
    #2;
    reset        = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (out_flag !== 1'b0 || match_count !== 8'd0) begin
      n_errors++;
      $display("FAIL reset: got flag=%b count=%0d, want flag=0 count=0", out_flag, match_count);
    end
    n_checks++;
    if (out_flag2 !== 1'b0 || match_count2 !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_cnt2: got flag=%b count=%0d, want flag=0 count=0", out_flag2, match_count2);
    end
    reset = 1'b1;
  endtask

  task automatic test_default_pattern();
    logic [8:0] v  = 9'b111111000;
    logic [8:0] b  = 9'b110100000;
    logic [8:0] ef = 9'b000100000;
    int         ec[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
    exp_t       e;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(v[8-i], b[8-i], 1'b0, 4'h0, 1'b0);
      e.flag = ef[8-i];
      e.cnt  = 8'(ec[i]);
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front();
      n_checks++;
      if (out_flag !== e.flag || match_count !== e.cnt) begin
        n_errors++;
        $display("FAIL default[%0d]: got flag=%b count=%0d, want flag=%b count=%0d",
                 i, out_flag, match_count, e.flag, e.cnt);
      end
    end
  endtask

  task automatic test_overlap(input logic ov);
    logic [6:0] b  = 7'b1101101;
    logic [6:0] ef = ov ? 7'b0001001 : 7'b0001000;
    int         ec_ov[7] = '{0, 0, 0, 1, 1, 1, 2};
    int         ec_no[7] = '{0, 0, 0, 1, 1, 1, 1};
    exp_t       e;
    apply_reset();
    overlap_en = ov;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, b[6-i], 1'b0, 4'h0, 1'b0);
      e.flag = ef[6-i];
      e.cnt  = ov ? 8'(ec_ov[i]) : 8'(ec_no[i]);
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front();
      n_checks++;
      if (out_flag !== e.flag || match_count !== e.cnt) begin
        n_errors++;
        $display("FAIL overlap_en=%b[%0d]: got flag=%b count=%0d, want flag=%b count=%0d",
                 ov, i, out_flag, match_count, e.flag, e.cnt);
      end
    end
  endtask

  task automatic test_gap();
    logic [9:0] v  = 10'b1111000001;
    logic [9:0] b  = 10'b1101010101;
    logic [9:0] ef = 10'b0001111110;
    int         ec[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    exp_t       e;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(v[9-i], b[9-i], 1'b0, 4'h0, 1'b0);
      e.flag = ef[9-i];
      e.cnt  = 8'(ec[i]);
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front();
      n_checks++;
      if (out_flag !== e.flag || match_count !== e.cnt) begin
        n_errors++;
        $display("FAIL gap[%0d]: got flag=%b count=%0d, want flag=%b count=%0d",
                 i, out_flag, match_count, e.flag, e.cnt);
      end
    end
  endtask

  task automatic test_reprogram();
    logic [7:0] b  = 8'b11010101;
    logic [7:0] ld = 8'b00010000;
    logic [7:0] ef = 8'b00000001;
    int         ec[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    exp_t       e;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, b[7-i], ld[7-i], 4'b0101, 1'b0);
      e.flag = ef[7-i];
      e.cnt  = 8'(ec[i]);
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front();
      n_checks++;
      if (out_flag !== e.flag || match_count !== e.cnt) begin
        n_errors++;
        $display("FAIL reprogram[%0d]: got flag=%b count=%0d, want flag=%b count=%0d",
                 i, out_flag, match_count, e.flag, e.cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] b  = 11'b11011101101;
    logic [10:0] ef = 11'b00010000001;
    int          ec[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    exp_t        e;
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, b[10-i], 1'b0, 4'h0, 1'b0);
      e.flag = ef[10-i];
      e.cnt  = 8'(ec[i]);
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front();
      n_checks++;
      if (out_flag !== e.flag || match_count !== e.cnt) begin
        n_errors++;
        $display("FAIL async_reset[%0d]: got flag=%b count=%0d, want flag=%b count=%0d",
                 i, out_flag, match_count, e.flag, e.cnt);
      end
      if (i == 3 || i == 6) begin
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (out_flag !== 1'b0 || match_count !== 8'd0) begin
          n_errors++;
          $display("FAIL async_reset_now[%0d]: got flag=%b count=%0d, want flag=0 count=0",
                   i, out_flag, match_count);
        end
        #1 reset = 1'b1;
      end
    end
  endtask

  task automatic test_counter_saturation();
    logic [10:0] v   = 11'b01111111110;
    logic [10:0] ld  = 11'b10000000000;
    logic [10:0] clr = 11'b00000000101;
    logic [10:0] ef  = 11'b00001111111;
    int          ec[11] = '{0, 0, 0, 0, 1, 2, 3, 3, 0, 1, 0};
    exp_t        e;
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      drive(v[10-i], v[10-i], ld[10-i], 4'b1111, clr[10-i]);
      e.flag = ef[10-i];
      e.cnt  = 8'(ec[i]);
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front();
      n_checks++;
      if (out_flag2 !== e.flag || {6'b0, match_count2} !== e.cnt) begin
        n_errors++;
        $display("FAIL count_sat[%0d]: got flag=%b count=%0d, want flag=%b count=%0d",
                 i, out_flag2, match_count2, e.flag, e.cnt);
      end
    end
  endtask

  initial begin
    reset        = 1'b0;
    bit_valid    = 1'b0;
    bit_in       = 1'b0;
    pattern_load = 1'b0;
    pattern_in   = 4'h0;
    overlap_en   = 1'b1;
    count_clear  = 1'b0;

    test_reset();
    test_default_pattern();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_gap();
    test_reprogram();
    test_async_reset();
    test_counter_saturation();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Parametrised, runtime-programmable serial bit-sequence detector. Moore-style: flag is a function of registered state only.
- Next generation of the fixed 4-bit Moore detector. Adds:
  - width parameter
  - loadable pattern
  - overlap / non-overlap mode
  - input qualifier
  - saturating match counter
- Sits between a serial bit source and control logic that consumes the match flag and count.

Parameters:
- PATTERN_W, 4, pattern length in bits (>=2).
- DEFAULT_PATTERN, 4'b1101, pattern loaded at reset. MSB is the first bit in time.
- COUNT_W, 8, match counter width.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- bit_valid  input  1  qualifies bit_in. Bit is consumed only on an edge where bit_valid=1.
- bit_in  input  1  serial data bit.
- pattern_load  input  1  loads pattern_in and clears history.
- pattern_in  input  PATTERN_W  new pattern, MSB first in time.
- overlap_en  input  1  1 = overlapping matches allowed; 0 = restart after each match.
- count_clear  input  1  synchronous clear of match_count.
- out_flag  output  1  high while the detector is in the match state.
- match_count  output  COUNT_W  number of match-state entries, saturating.

Behaviour:
- Reset (reset=0, async) values:
  - pattern = DEFAULT_PATTERN
  - hist = 0, fill = 0
  - out_flag = 0, match_count = 0
  - Effective immediately, no clock needed. Reset mid-sequence discards all partial history.
- State:
  - hist[PATTERN_W-1:0]: last bits received. Newest bit enters at LSB.
  - fill: count of valid bits held, 0..PATTERN_W, saturating.
  - pattern register.
- Match state is defined as fill==PATTERN_W and hist==pattern. out_flag is a registered copy of this condition.
- Latency: out_flag rises in the cycle after the edge that sampled the final pattern bit. This matches fixed Moore timing.
- On an edge with bit_valid=1 and no pattern_load:
  - Overlap case (overlap_en=1, or out_flag currently 0):
    - hist <= {hist[PATTERN_W-2:0], bit_in}
    - fill <= min(fill+1, PATTERN_W)
  - Non-overlap restart (overlap_en=0 and out_flag currently 1):
    - hist <= {zeros, bit_in}
    - fill <= 1
- bit_valid=0: all state holds. out_flag keeps its value, so the match state persists across gaps until the next valid bit.
- pattern_load=1 has priority over bit_valid:
  - pattern <= pattern_in
  - hist <= 0, fill <= 0, out_flag <= 0
  - The coincident bit is dropped.
- match_count increments on every edge where the next out_flag is 1 and the current out_flag is 0, or the edge consumed a valid bit (i.e. each new match event).
  - Saturates at 2^COUNT_W-1.
  - count_clear has priority over an increment in the same cycle; result is 0.
- overlap_en is sampled on every valid bit. Changing it mid-stream takes effect on the next valid bit.
- Pattern all-zeros or all-ones is legal. In overlap mode, a run of such bits yields a match on every valid bit after fill reaches PATTERN_W.

Optional Feature:
- Macro: SEQ_DETECT_PROG_MASK_EN.
- Defined:
  - Adds input mask_in [PATTERN_W] and a mask register, loaded alongside pattern on pattern_load.
  - Reset value is all-ones.
  - Match compare becomes ((hist ^ pattern) & mask)==0. A mask bit of 0 is don't-care.
- Undefined:
  - No mask port, no mask register.
  - Exact compare only.

Decomposition:
- Package seq_detect_pkg holds:
  - default PATTERN_W / COUNT_W constants
  - DEFAULT_PATTERN constant
  - typedef for the fill counter width ($clog2(PATTERN_W+1))
- One sub-module, seq_detect_hist: owns hist + fill update (shift, restart, clear).
- The top holds the pattern/mask register, compare, out_flag and the counter.

Test Plan:
- Default pattern after reset. Valid bits 1,1,0,1 -> out_flag=1 in the cycle after the 4th bit edge; match_count=1. Bits 0,0 then hold -> out_flag=0 and stays 0.
- overlap_en=1, bits 1,1,0,1,1,0,1 -> out_flag pulses after bit 4 and bit 7; match_count=2. Same stream with overlap_en=0 -> single match; match_count=1.
- Match state across gaps: bits 1,1,0,1, then bit_valid=0 for 5 cycles -> out_flag held high for all 5 cycles; match_count stays 1.
- Reprogramming mid-stream: bits 1,1,0, then pattern_load with pattern_in=4'b0101 together with bit_valid=1, bit_in=1. Bit is dropped and fill=0; then bits 0,1,0,1 -> match; match_count=1.
- Async reset mid-sequence: bits 1,1,0, pulse reset low between edges -> out_flag=0 immediately; then bit 1 -> no match.
- Counter boundaries, COUNT_W=2, overlap_en=1, pattern 4'b1111:
  - Seven 1s -> four matches; match_count saturates at 3.
  - Then count_clear coincident with a match -> match_count=0.
